// File: rtl/vfxp_pkg.sv
// Shared encodings and per-element rounding helpers for the vector fixed-point writeback path.
package vfxp_pkg;

  typedef enum logic [1:0] {
    VXRM_RNU = 2'd0,
    VXRM_RNE = 2'd1,
    VXRM_RDN = 2'd2,
    VXRM_ROD = 2'd3
  } vxrm_e;

  typedef enum logic [1:0] {
    SEW_8  = 2'd0,
    SEW_16 = 2'd1,
    SEW_32 = 2'd2,
    SEW_64 = 2'd3
  } sew_e;

  // Rounding increment for one element from its shifted-out bit (vd) and result LSB (vd1).
  function automatic logic round_inc(input logic [1:0] vxrm, input logic vd, input logic vd1);
    logic inc;
    case (vxrm)
      VXRM_RNU: inc = vd;
      VXRM_RNE: inc = vd & vd1;
      VXRM_RDN: inc = 1'b0;
      default:  inc = vd & ~vd1;
    endcase
    return inc;
  endfunction

  // True when byte_idx is the lowest byte of an element of the given width.
  function automatic logic is_elem_base(input int byte_idx, input logic [1:0] sew);
    logic base;
    case (sew)
      SEW_8:   base = 1'b1;
      SEW_16:  base = (byte_idx % 2) == 0;
      SEW_32:  base = (byte_idx % 4) == 0;
      default: base = (byte_idx % 8) == 0;
    endcase
    return base;
  endfunction

endpackage

// File: rtl/vfxp_rounder.sv
// Combinational per-element rounding increment; carries ripple byte to byte but are
// restarted at every element base, so nothing crosses an element boundary.
module vfxp_rounder
  import vfxp_pkg::*;
#(
  parameter int DATA_WIDTH    = 64,
  parameter int BE_WIDTH      = DATA_WIDTH / 8,
  parameter int ENABLE_64_BIT = 0
) (
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [BE_WIDTH-1:0]   i_vd,
  input  logic [BE_WIDTH-1:0]   i_vd1,
  input  logic [1:0]            i_sew,
  input  logic [1:0]            i_vxrm,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic w_en_round;
  logic w_carry;

  assign w_en_round = (i_sew != SEW_64) || (ENABLE_64_BIT != 0);

  always_comb begin
    o_data  = i_data;
    w_carry = 1'b0;
    for (int b = 0; b < BE_WIDTH; b++) begin
      // At an element base the incoming carry is replaced by that element's increment.
      if (is_elem_base(b, i_sew)) begin
        w_carry = round_inc(i_vxrm, i_vd[b], i_vd1[b]) & w_en_round;
      end
      {w_carry, o_data[8*b +: 8]} = {1'b0, i_data[8*b +: 8]} + {8'd0, w_carry};
    end
  end

endmodule

// File: rtl/vadd_fxp_wb.sv
// Writeback stage after the vector add pipeline: registered rounding stage feeding a
// show-ahead FIFO that drains to the register-file write port.
module vadd_fxp_wb
  import vfxp_pkg::*;
#(
  parameter int DATA_WIDTH    = 64,
  parameter int BE_WIDTH      = DATA_WIDTH / 8,
  parameter int ADDR_WIDTH    = 32,
  parameter int DEPTH         = 8,
  parameter int AFULL_SLACK   = 6,
  parameter int ENABLE_64_BIT = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_vec,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [BE_WIDTH-1:0]   in_be,
  input  logic                  in_mask,
  input  logic                  in_fxp,
  input  logic [BE_WIDTH-1:0]   in_vd,
  input  logic [BE_WIDTH-1:0]   in_vd1,
  input  logic [1:0]            in_sew,
  input  logic [1:0]            vxrm,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic [ADDR_WIDTH-1:0] wb_addr,
  output logic [BE_WIDTH-1:0]   wb_be,
  output logic                  wb_mask,
  output logic                  afull,
  output logic                  err_overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int AFULL_LVL = (AFULL_SLACK >= DEPTH) ? 0 : (DEPTH - AFULL_SLACK);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_TH = CNT_W'(AFULL_LVL);

  // Round stage
  logic [DATA_WIDTH-1:0] w_rounded;
  logic                  r_rs_valid;
  logic [DATA_WIDTH-1:0] r_rs_data;
  logic [ADDR_WIDTH-1:0] r_rs_addr;
  logic [BE_WIDTH-1:0]   r_rs_be;
  logic                  r_rs_mask;

  vfxp_rounder #(
    .DATA_WIDTH   (DATA_WIDTH),
    .BE_WIDTH     (BE_WIDTH),
    .ENABLE_64_BIT(ENABLE_64_BIT)
  ) u_rounder (
    .i_data(in_vec),
    .i_vd  (in_vd),
    .i_vd1 (in_vd1),
    .i_sew (in_sew),
    .i_vxrm(vxrm),
    .o_data(w_rounded)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rs_valid <= 1'b0;
      r_rs_data  <= '0;
      r_rs_addr  <= '0;
      r_rs_be    <= '0;
      r_rs_mask  <= 1'b0;
    end else begin
      r_rs_valid <= in_valid;
      r_rs_data  <= in_fxp ? w_rounded : in_vec;
      r_rs_addr  <= in_addr;
      r_rs_be    <= in_be;
      r_rs_mask  <= in_mask;
    end
  end

  // FIFO storage and control
  logic [DATA_WIDTH-1:0] r_mem_data [DEPTH];
  logic [ADDR_WIDTH-1:0] r_mem_addr [DEPTH];
  logic [BE_WIDTH-1:0]   r_mem_be   [DEPTH];
  logic                  r_mem_mask [DEPTH];
  logic [PTR_W-1:0]      r_wptr;
  logic [PTR_W-1:0]      r_rptr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_err;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_push_ok;
  logic                  w_overflow;

  // Write-port handshake: a beat transfers on any rising edge where wb_valid and wb_ready
  // are both high; wb_valid never drops and the head fields never change while waiting.
  assign wb_valid   = (r_count != '0);
  assign w_pop      = wb_valid & wb_ready;
  assign w_full     = (r_count == FULL_CNT);
  assign w_push_ok  = r_rs_valid & (~w_full | w_pop);
  assign w_overflow = r_rs_valid & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (!rst && w_push_ok) begin
      r_mem_data[r_wptr] <= r_rs_data;
      r_mem_addr[r_wptr] <= r_rs_addr;
      r_mem_be[r_wptr]   <= r_rs_be;
      r_mem_mask[r_wptr] <= r_rs_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)     r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_overflow) r_err <= 1'b1;
    end
  end

  // Head fields are forced to zero when empty so stale storage never shows on the port.
  assign wb_data      = wb_valid ? r_mem_data[r_rptr] : '0;
  assign wb_addr      = wb_valid ? r_mem_addr[r_rptr] : '0;
  assign wb_be        = wb_valid ? r_mem_be[r_rptr]   : '0;
  assign wb_mask      = wb_valid ? r_mem_mask[r_rptr] : 1'b0;
  assign afull        = (r_count >= AFULL_TH);
  assign err_overflow = r_err;

endmodule

// File: tb/tb_vadd_fxp_wb.sv
// Directed bench for vadd_fxp_wb: expected beats queue up at issue, a forked monitor
// pops and compares them whenever the write port handshakes.
module tb_vadd_fxp_wb;
  import vfxp_pkg::*;

  localparam int DW = 64;
  localparam int AW = 32;
  localparam int BW = 8;
  localparam int W  = DW + AW + BW + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_vec;
  logic [AW-1:0] in_addr;
  logic [BW-1:0] in_be;
  logic          in_mask;
  logic          in_fxp;
  logic [BW-1:0] in_vd;
  logic [BW-1:0] in_vd1;
  logic [1:0]    in_sew;
  logic [1:0]    vxrm;
  logic          wb_valid;
  logic          wb_ready;
  logic [DW-1:0] wb_data;
  logic [AW-1:0] wb_addr;
  logic [BW-1:0] wb_be;
  logic          wb_mask;
  logic          afull;
  logic          err_overflow;

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];

  vadd_fxp_wb dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_vec(in_vec), .in_addr(in_addr), .in_be(in_be),
    .in_mask(in_mask), .in_fxp(in_fxp), .in_vd(in_vd), .in_vd1(in_vd1),
    .in_sew(in_sew), .vxrm(vxrm),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_addr(wb_addr),
    .wb_be(wb_be), .wb_mask(wb_mask), .afull(afull), .err_overflow(err_overflow)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // Drivers
  task automatic set_beat(input logic [DW-1:0] vec, input logic [AW-1:0] addr,
                          input logic [BW-1:0] be, input logic mask, input logic fxp,
                          input logic [BW-1:0] vd, input logic [BW-1:0] vd1,
                          input logic [1:0] sew, input logic [1:0] rm,
                          input logic [DW-1:0] exp_data, input bit exp_en);
    in_valid = 1'b1;
    in_vec   = vec;
    in_addr  = addr;
    in_be    = be;
    in_mask  = mask;
    in_fxp   = fxp;
    in_vd    = vd;
    in_vd1   = vd1;
    in_sew   = sew;
    vxrm     = rm;
    if (exp_en) exp_q.push_back({exp_data, addr, be, mask});
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
    in_vec   = '0;
    in_addr  = '0;
    in_be    = '0;
    in_mask  = 1'b0;
    in_fxp   = 1'b0;
    in_vd    = '0;
    in_vd1   = '0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    rst      = 1'b1;
    wb_ready = 1'b0;
    in_sew   = 2'd0;
    vxrm     = 2'd0;
    idle_in();

    fork
      // Scoreboard monitor
      forever begin
        logic [W-1:0] exp_beat;
        @(negedge clk);
        if (!rst && wb_valid && wb_ready) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL wb_unexpected got %h expected none", {wb_data, wb_addr, wb_be, wb_mask});
          end else begin
            exp_beat = exp_q.pop_front();
            if ({wb_data, wb_addr, wb_be, wb_mask} !== exp_beat) begin
              n_errors++;
              $display("FAIL wb_beat got %h expected %h", {wb_data, wb_addr, wb_be, wb_mask}, exp_beat);
            end
          end
        end
      end
      begin
        #200000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
      end
    join_none

    repeat (3) step();
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_afull", 64'(afull), 64'd0);
    chk("rst_err", 64'(err_overflow), 64'd0);
    chk("rst_wb_data", wb_data, 64'd0);
    rst      = 1'b0;
    wb_ready = 1'b1;
    step();

    // Latency: one beat, visible two edges after it is sampled
    set_beat(64'h0123_4567_89AB_CD10, 32'h100, 8'hFF, 1'b0, 1'b1, 8'h01, 8'h00, SEW_8, VXRM_RNU,
             64'h0123_4567_89AB_CD11, 1'b1);
    step();
    idle_in();
    chk("lat_e0_valid", 64'(wb_valid), 64'd0);
    step();
    chk("lat_e1_valid", 64'(wb_valid), 64'd1);
    wait_drain("drain_lat", 10);

    // Rounding vectors, back to back
    set_beat(64'h20, 32'h108, 8'h01, 1'b0, 1'b1, 8'h01, 8'h00, SEW_8, VXRM_RNE, 64'h20, 1'b1); step();
    set_beat(64'h21, 32'h110, 8'h03, 1'b0, 1'b1, 8'h01, 8'h01, SEW_8, VXRM_RNE, 64'h22, 1'b1); step();
    set_beat(64'h33, 32'h118, 8'h07, 1'b0, 1'b1, 8'h01, 8'h01, SEW_8, VXRM_ROD, 64'h33, 1'b1); step();
    set_beat(64'h32, 32'h120, 8'h0F, 1'b0, 1'b1, 8'h01, 8'h00, SEW_8, VXRM_ROD, 64'h33, 1'b1); step();
    set_beat(64'h5555_5555_5555_5555, 32'h128, 8'hFF, 1'b0, 1'b1, 8'hFF, 8'hFF, SEW_8, VXRM_RDN,
             64'h5555_5555_5555_5555, 1'b1); step();
    set_beat(64'h00FF, 32'h130, 8'hFF, 1'b0, 1'b1, 8'h01, 8'h00, SEW_8, VXRM_RNU, 64'h0000, 1'b1); step();
    set_beat(64'hFFFF_FFFF_FFFF_FFFF, 32'h138, 8'hFF, 1'b0, 1'b1, 8'hFF, 8'h00, SEW_8, VXRM_RNU,
             64'h0, 1'b1); step();
    set_beat(64'h0000_0000_7F00_0000, 32'h140, 8'hF0, 1'b0, 1'b1, 8'h08, 8'h08, SEW_8, VXRM_RNE,
             64'h0000_0000_8000_0000, 1'b1); step();
    set_beat(64'h1234_0000_0000_00FF, 32'h148, 8'hFF, 1'b0, 1'b1, 8'h13, 8'h00, SEW_16, VXRM_RNU,
             64'h1234_0001_0000_0100, 1'b1); step();
    set_beat(64'h0000_0001_FFFF_FFFF, 32'h150, 8'hFF, 1'b0, 1'b1, 8'h11, 8'h00, SEW_32, VXRM_RNU,
             64'h0000_0002_0000_0000, 1'b1); step();
    set_beat(64'h00FF, 32'h158, 8'hFF, 1'b0, 1'b1, 8'hFF, 8'h00, SEW_64, VXRM_RNU, 64'h00FF, 1'b1); step();
    set_beat(64'hABCD, 32'hDEAD_BEE0, 8'h3C, 1'b1, 1'b0, 8'hFF, 8'h00, SEW_8, VXRM_RNU, 64'hABCD, 1'b1); step();
    idle_in();
    wait_drain("drain_round", 30);
    chk("round_no_ovf", 64'(err_overflow), 64'd0);

    // Overflow: nine beats into eight slots with the port stalled
    wb_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      set_beat(64'h1000 + 64'(i), 32'h200 + 32'(i), 8'hFF, 1'b0, 1'b0, 8'h00, 8'h00, SEW_8, VXRM_RNU,
               64'h1000 + 64'(i), i < 8);
      step();
      if (i == 1) chk("afull_cnt1", 64'(afull), 64'd0);
      if (i == 2) chk("afull_cnt2", 64'(afull), 64'd1);
      if (i == 8) chk("ovf_before_drop", 64'(err_overflow), 64'd0);
    end
    idle_in();
    step();
    chk("ovf_set", 64'(err_overflow), 64'd1);
    chk("ovf_afull", 64'(afull), 64'd1);
    chk("ovf_head_valid", 64'(wb_valid), 64'd1);
    chk("ovf_head_data", wb_data, 64'h1000);
    wb_ready = 1'b1;
    wait_drain("drain_ovf", 20);
    step();
    step();
    chk("ovf_empty", 64'(wb_valid), 64'd0);

    // Reset clears sticky error, then push into a full FIFO alongside a pop
    wb_ready = 1'b0;
    rst      = 1'b1;
    step();
    chk("rst_err_clear", 64'(err_overflow), 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      set_beat(64'h2000 + 64'(i), 32'h300 + 32'(i), 8'h0F, 1'b0, 1'b0, 8'h00, 8'h00, SEW_8, VXRM_RNU,
               64'h2000 + 64'(i), 1'b1);
      step();
      if (i == 8) begin
        chk("full_no_ovf", 64'(err_overflow), 64'd0);
        wb_ready = 1'b1;
      end
    end
    idle_in();
    step();
    chk("full_pushpop_no_ovf", 64'(err_overflow), 64'd0);
    chk("full_pushpop_afull", 64'(afull), 64'd1);
    wait_drain("drain_full", 30);

    // Reset mid-stream with the FIFO overflowed and a beat presented during reset
    wb_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      set_beat(64'h3000 + 64'(i), 32'h400 + 32'(i), 8'hFF, 1'b0, 1'b0, 8'h00, 8'h00, SEW_8, VXRM_RNU,
               64'h0, 1'b0);
      step();
    end
    chk("mid_ovf_set", 64'(err_overflow), 64'd1);
    set_beat(64'h3FFF, 32'h4FF, 8'hFF, 1'b0, 1'b0, 8'h00, 8'h00, SEW_8, VXRM_RNU, 64'h0, 1'b0);
    rst = 1'b1;
    step();
    chk("mid_rst_valid", 64'(wb_valid), 64'd0);
    chk("mid_rst_afull", 64'(afull), 64'd0);
    chk("mid_rst_err", 64'(err_overflow), 64'd0);
    chk("mid_rst_data", wb_data, 64'd0);
    chk("mid_rst_addr", 64'(wb_addr), 64'd0);
    rst = 1'b0;
    idle_in();
    wb_ready = 1'b1;
    step();
    chk("post_rst_valid1", 64'(wb_valid), 64'd0);
    step();
    chk("post_rst_valid2", 64'(wb_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
